// File: rtl/nebula_pkg.sv
// Shared types and constants for the nebula arbitration blocks.
package nebula_pkg;

  typedef enum logic {
    ARB_IDLE_S,
    ARB_LOCKED_S
  } arb_state_e;

  localparam int NEBULA_ARB_WEIGHT_W = 4;

endpackage : nebula_pkg

// File: rtl/nebula_rr_pick.sv
// Rotating-priority picker: finds the first set request at or after ptr,
// wrapping from N-1 back to 0. Purely combinational.
module nebula_rr_pick
  import nebula_pkg::*;
#(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scan N candidates starting at ptr; the wrap is explicit so a
  // non-power-of-2 N never lands on an unused index.
  always_comb begin
    int  cand;
    logic found;
    onehot_o = '0;
    idx_o    = '0;
    any_o    = |req_i;
    found    = 1'b0;
    cand     = (int'(ptr_i) < N) ? int'(ptr_i) : 0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        onehot_o[cand] = 1'b1;
        idx_o          = IW'(cand);
      end
      cand = (cand == N - 1) ? 0 : cand + 1;
    end
  end

endmodule : nebula_rr_pick

// File: rtl/nebula_wrr_arbiter.sv
// Weighted round-robin arbiter with packet locking.
//
//   state        | meaning
//   -------------+---------------------------------------------------
//   ARB_IDLE_S   | free arbitration from ptr among all requesters
//   ARB_LOCKED_S | mid-packet; only the owner may be granted
module nebula_wrr_arbiter
  import nebula_pkg::*;
#(
  parameter int NUM_REQS     = 5,
  parameter int REQ_WIDTH    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  parameter int WEIGHT_WIDTH = NEBULA_ARB_WEIGHT_W,
  parameter bit LOCK_EN      = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQS-1:0]              req,
  input  logic [NUM_REQS-1:0]              req_last,
  input  logic [NUM_REQS*WEIGHT_WIDTH-1:0] weight,
  input  logic                             grant_ready,
  output logic [NUM_REQS-1:0]              grant,
  output logic                             grant_valid,
  output logic [REQ_WIDTH-1:0]             grant_id,
  output logic                             locked
);

  arb_state_e               state_q, state_d;
  logic [REQ_WIDTH-1:0]     ptr_q, ptr_d;
  logic [WEIGHT_WIDTH-1:0]  served_q, served_d;
  logic [REQ_WIDTH-1:0]     owner_q, owner_d;

  logic [NUM_REQS-1:0]      pick_onehot;
  logic [REQ_WIDTH-1:0]     pick_idx;
  logic                     pick_any;

  nebula_rr_pick #(
    .N  (NUM_REQS),
    .IW (REQ_WIDTH)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // Grant selection: the picker while arbitrating, the owner alone while
  // locked. Everything is forced to zero during reset.
  always_comb begin
    logic [NUM_REQS-1:0] lk_grant;
    lk_grant = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      lk_grant[i] = (owner_q == REQ_WIDTH'(i)) & req[i];
    end
    grant    = '0;
    grant_id = '0;
    if (!rst) begin
      if (state_q == ARB_LOCKED_S) begin
        grant    = lk_grant;
        grant_id = (|lk_grant) ? owner_q : '0;
      end else if (pick_any) begin
        grant    = pick_onehot;
        grant_id = pick_idx;
      end
    end
    grant_valid = |grant;
    locked      = (state_q == ARB_LOCKED_S) && !rst;
  end

  // Next-state: lock on a non-tail accept, update the weighted turn on
  // packet completion. Nothing moves without an accept.
  always_comb begin
    logic                    accept;
    logic                    is_tail;
    logic [WEIGHT_WIDTH-1:0] wt;
    logic [WEIGHT_WIDTH-1:0] wt_eff;
    logic [WEIGHT_WIDTH-1:0] s;
    state_d  = state_q;
    ptr_d    = ptr_q;
    served_d = served_q;
    owner_d  = owner_q;
    accept   = grant_valid & grant_ready;
    is_tail  = 1'b0;
    wt       = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant_id == REQ_WIDTH'(i)) begin
        wt      = weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        is_tail = req_last[i];
      end
    end
    if (!LOCK_EN) is_tail = 1'b1;
    wt_eff = (wt == '0) ? WEIGHT_WIDTH'(1) : wt;
    // served saturates rather than wrapping back below the weight
    if (grant_id == ptr_q) begin
      s = (served_q == '1) ? served_q : served_q + 1'b1;
    end else begin
      s = WEIGHT_WIDTH'(1);
    end
    if (accept) begin
      if (!is_tail) begin
        state_d = ARB_LOCKED_S;
        owner_d = grant_id;
      end else begin
        state_d = ARB_IDLE_S;
        if (s >= wt_eff) begin
          ptr_d    = (grant_id == REQ_WIDTH'(NUM_REQS - 1)) ? '0 : grant_id + 1'b1;
          served_d = '0;
        end else begin
          ptr_d    = grant_id;
          served_d = s;
        end
      end
    end
  end

  // State registers with synchronous reset; reset also drops any lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE_S;
      ptr_q    <= '0;
      served_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      served_q <= served_d;
      owner_q  <= owner_d;
    end
  end

endmodule : nebula_wrr_arbiter

// File: tb/tb_nebula_wrr_arbiter.sv
// Directed scoreboard bench for nebula_wrr_arbiter (4 requesters, locking on).
module tb_nebula_wrr_arbiter;

  localparam int N  = 4;
  localparam int RW = 2;
  localparam int WW = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    req_last;
  logic [N*WW-1:0] weight;
  logic            grant_ready;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [RW-1:0]   grant_id;
  logic            locked;

  typedef struct {
    logic [N-1:0]  g;
    logic          gv;
    logic [RW-1:0] id;
    logic          lk;
    string         nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_bad;

  nebula_wrr_arbiter #(
    .NUM_REQS     (N),
    .REQ_WIDTH    (RW),
    .WEIGHT_WIDTH (WW),
    .LOCK_EN      (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_last    (req_last),
    .weight      (weight),
    .grant_ready (grant_ready),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .locked      (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] idx_of(input logic [N-1:0] oh);
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (oh[i]) r = RW'(i);
    return r;
  endfunction

  function automatic void chk(input string nm, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endfunction

  // Drive one cycle of inputs and queue what the outputs must be this cycle.
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lst,
                      input logic rdy, input logic [N-1:0] eg, input logic elk,
                      input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst         = r;
    req         = rq;
    req_last    = lst;
    grant_ready = rdy;
    e.g  = eg;
    e.gv = |eg;
    e.id = idx_of(eg);
    e.lk = elk;
    e.nm = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: sample mid-cycle, pop the expectation for this cycle and
  // check the structural invariants alongside it.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.nm, ".grant"},  int'(grant),       int'(e.g));
      chk({e.nm, ".valid"},  int'(grant_valid), int'(e.gv));
      chk({e.nm, ".id"},     int'(grant_id),    int'(e.id));
      chk({e.nm, ".locked"}, int'(locked),      int'(e.lk));
      chk({e.nm, ".onehot0"}, int'($onehot0(grant)), 1);
      chk({e.nm, ".subset"},  int'((grant & ~req) == '0), 1);
    end
  end

  initial begin
    n_vec       = 0;
    n_bad       = 0;
    rst         = 1'b1;
    req         = '1;
    req_last    = '1;
    grant_ready = 1'b1;
    weight      = {4'd1, 4'd1, 4'd1, 4'd1};

    // 1: reset holds outputs low, then idle
    repeat (3) step(1, 4'b1111, 4'b1111, 1, 4'b0000, 0, "t1_rst");
    step(0, 4'b0000, 4'b1111, 1, 4'b0000, 0, "t1_idle");

    // 2: equal weights rotate 0,1,2,3,0,1
    step(0, 4'b1111, 4'b1111, 1, 4'b0001, 0, "t2_c0");
    step(0, 4'b1111, 4'b1111, 1, 4'b0010, 0, "t2_c1");
    step(0, 4'b1111, 4'b1111, 1, 4'b0100, 0, "t2_c2");
    step(0, 4'b1111, 4'b1111, 1, 4'b1000, 0, "t2_c3");
    step(0, 4'b1111, 4'b1111, 1, 4'b0001, 0, "t2_c4");
    step(0, 4'b1111, 4'b1111, 1, 4'b0010, 0, "t2_c5");

    // 3: weights w0=3 w1=1 w2=2 w3=0 -> 0,0,0,1,2,2,3,0,0,0
    step(1, 4'b0000, 4'b1111, 1, 4'b0000, 0, "t3_rst");
    weight = {4'd0, 4'd2, 4'd1, 4'd3};
    step(0, 4'b1111, 4'b1111, 1, 4'b0001, 0, "t3_c0");
    step(0, 4'b1111, 4'b1111, 1, 4'b0001, 0, "t3_c1");
    step(0, 4'b1111, 4'b1111, 1, 4'b0001, 0, "t3_c2");
    step(0, 4'b1111, 4'b1111, 1, 4'b0010, 0, "t3_c3");
    step(0, 4'b1111, 4'b1111, 1, 4'b0100, 0, "t3_c4");
    step(0, 4'b1111, 4'b1111, 1, 4'b0100, 0, "t3_c5");
    step(0, 4'b1111, 4'b1111, 1, 4'b1000, 0, "t3_c6");
    step(0, 4'b1111, 4'b1111, 1, 4'b0001, 0, "t3_c7");
    step(0, 4'b1111, 4'b1111, 1, 4'b0001, 0, "t3_c8");
    step(0, 4'b1111, 4'b1111, 1, 4'b0001, 0, "t3_c9");

    // 4a: four-beat packet on req0 holds the grant, then req1
    step(1, 4'b0000, 4'b1111, 1, 4'b0000, 0, "t4_rst");
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
    step(0, 4'b0011, 4'b0010, 1, 4'b0001, 0, "t4_b1");
    step(0, 4'b0011, 4'b0010, 1, 4'b0001, 1, "t4_b2");
    step(0, 4'b0011, 4'b0010, 1, 4'b0001, 1, "t4_b3");
    step(0, 4'b0011, 4'b0011, 1, 4'b0001, 1, "t4_b4");
    step(0, 4'b0011, 4'b0011, 1, 4'b0010, 0, "t4_c5");

    // 4b: owner drops its request mid-packet; others stay blocked
    step(1, 4'b0000, 4'b1111, 1, 4'b0000, 0, "t4r_rst");
    step(0, 4'b0011, 4'b0010, 1, 4'b0001, 0, "t4r_b1");
    step(0, 4'b0010, 4'b0010, 1, 4'b0000, 1, "t4r_gap1");
    step(0, 4'b0010, 4'b0010, 1, 4'b0000, 1, "t4r_gap2");
    step(0, 4'b0011, 4'b0010, 1, 4'b0001, 1, "t4r_b3");
    step(0, 4'b0011, 4'b0011, 1, 4'b0001, 1, "t4r_b4");
    step(0, 4'b0010, 4'b0010, 1, 4'b0010, 0, "t4r_next");

    // 5: backpressure holds grant and pointer
    step(1, 4'b0000, 4'b1111, 1, 4'b0000, 0, "t5_rst");
    step(0, 4'b1111, 4'b1111, 0, 4'b0001, 0, "t5_hold0");
    step(0, 4'b1111, 4'b1111, 0, 4'b0001, 0, "t5_hold1");
    step(0, 4'b1111, 4'b1111, 0, 4'b0001, 0, "t5_hold2");
    step(0, 4'b1111, 4'b1111, 1, 4'b0001, 0, "t5_go0");
    step(0, 4'b1111, 4'b1111, 1, 4'b0010, 0, "t5_go1");

    // 6: reset mid-packet drops the lock and resets ptr
    step(1, 4'b0000, 4'b1111, 1, 4'b0000, 0, "t6_rst");
    step(0, 4'b0011, 4'b0010, 1, 4'b0001, 0, "t6_b1");
    step(1, 4'b0011, 4'b0010, 1, 4'b0000, 0, "t6_midrst");
    step(0, 4'b0110, 4'b0110, 1, 4'b0010, 0, "t6_after");

    // drain, bounded
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_nebula_wrr_arbiter
